multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle RV32I main control FSM. Decodes the opcode in the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU_CO/is_immediate pair consumed by ALU_Control, plus all datapath muxes and write enables.
- Sits between the instruction register/flags and the datapath; handshakes with a single-port memory via mem_req/mem_ready.

Parameters:
MEM_TIMEOUT, 0, max cycles waiting on mem_ready_i in a memory state; 0 disables the timeout.

Ports:
clk_i  input  1  clock, all state changes on rising edge
rst_n_i  input  1  reset, synchronous active-low
opcode_i  input  7  instr[6:0] from instruction register, stable outside FETCH
zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory completes the current access this cycle
mem_req_o  output  1  memory access request
mem_write_o  output  1  access is a store
adr_src_o  output  1  0=PC, 1=ALUOut
ir_write_o  output  1  load instruction register
pc_write_o  output  1  load PC
reg_write_o  output  1  register file write
alu_src_a_o  output  2  00=PC, 01=OldPC, 10=rs1, 11=zero
alu_src_b_o  output  2  00=rs2, 01=imm, 10=const 4
result_src_o  output  2  00=ALUOut, 01=mem data, 10=ALU result
ALU_CO_o  output  2  00=add, 01=sub, 10=funct-decoded (to ALU_Control)
is_immediate_o  output  1  I-type ALU op (to ALU_Control)
illegal_o  output  1  one-cycle pulse: unknown opcode or memory timeout
state_o  output  4  current state (debug)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low: while rst_n_i=0 at a rising edge, state <= RESET and the wait counter clears.
- RESET has all outputs 0. Reset mid-instruction aborts with no further writes.
- Moore outputs decoded from state, except four signals that are combinational on inputs:
  - ir_write_o and pc_write_o in FETCH (gated by mem_ready_i)
  - pc_write_o in BEQ (=zero_i)
  - illegal_o
- Every output not listed for a state is 0.
- States (encoding) and outputs -> next state:
  - RESET(0): -> FETCH.
  - FETCH(1): mem_req=1, adr_src=0, a=00, b=10, CO=00, result_src=10; ir_write=pc_write=mem_ready_i. Next: DECODE if mem_ready_i, else stay.
  - DECODE(2): a=01, b=01, CO=00 (branch/jump target to ALUOut). Next by opcode:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - 0110111 -> LUI
    - other -> FETCH with illegal_o=1 this cycle
  - MEMADR(3): a=10, b=01, CO=00. Next: MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD(4): mem_req=1, adr_src=1. Next: MEMWB when mem_ready_i.
  - MEMWB(5): result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE(6): mem_req=1, mem_write=1, adr_src=1. Next: FETCH when mem_ready_i.
  - EXECR(7): a=10, b=00, CO=10, is_immediate=0. Next: ALUWB.
  - EXECI(8): a=10, b=01, CO=10, is_immediate=1. Next: ALUWB.
  - ALUWB(9): result_src=00, reg_write=1. Next: FETCH.
  - JAL(10): a=01, b=10, CO=00, result_src=00, pc_write=1. Next: ALUWB (rd<=OldPC+4).
  - BEQ(11): a=10, b=00, CO=01, result_src=00, pc_write=zero_i. Next: FETCH.
  - LUI(12): a=11, b=01, CO=00. Next: ALUWB.
  - Codes 13-15: -> FETCH, illegal_o=1.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEMREAD/MEMWRITE with mem_ready_i=0; clears on any state change.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: illegal_o=1 that cycle, next state FETCH, no register or PC write.
  - mem_ready_i in the same cycle as the timeout wins: normal transition, no illegal_o.
- mem_ready_i outside the memory states is ignored.
- Cycle counts with zero wait: R/I/LUI 4, lw 5, sw 4, beq 3, jal 4.

Decomposition:
- Shared package holds:
  - opcode constants
  - state enum
  - ALU_CO encodings (ADD/SUB/FUNCT), shared with ALU_Control
  - mux-select encodings for a, b and result_src
- No sub-module needed. Wait counter and output decode stay inline: one next-state always block, one output decode block.

Test Plan:
- Reset then release, mem_ready_i=1, opcode=0110011 -> state_o 0,1,2,7,9,1. ALU_CO_o=10 and is_immediate_o=0 in EXECR; reg_write_o=1 only in ALUWB.
- opcode=0010011 -> EXECI with ALU_CO_o=10, is_immediate_o=1, alu_src_b_o=01. lw (0000011) with mem_ready_i low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src_o=01.
- beq with zero_i=1 -> pc_write_o=1 in BEQ with ALU_CO_o=01. Repeat with zero_i=0 -> pc_write_o=0; both return to FETCH.
- opcode=1111111 -> DECODE pulses illegal_o=1 and returns to FETCH, no reg_write_o/pc_write_o. jal -> JAL with pc_write_o=1, then ALUWB.
- MEM_TIMEOUT=4, sw (0100011) with mem_ready_i=0 -> illegal_o after 4 waiting cycles, then FETCH. rst_n_i=0 asserted in MEMWRITE -> next state RESET, all outputs 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, states,
// ALU_CO codes (also consumed by ALU_Control) and datapath mux selects.
package multicycle_control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_LUI      = 4'd12
  } state_e;

  localparam logic [1:0] ALU_CO_ADD   = 2'b00;
  localparam logic [1:0] ALU_CO_SUB   = 2'b01;
  localparam logic [1:0] ALU_CO_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // States that hold a memory access open until mem_ready_i.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath selects, write enables and the memory request.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] ALU_CO_o,
  output logic       is_immediate_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             waiting;
  logic             timeout;
  logic             decode_illegal;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive stalled cycle; a ready in
  // that same cycle takes the normal path instead.
  always_comb begin
    state_d        = state_q;
    decode_illegal = 1'b0;
    waiting        = is_mem_state(state_q) && !mem_ready_i;
    timeout        = (MEM_TIMEOUT != 0) && waiting && (wait_cnt_q == CNT_LAST);

    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d        = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      default: begin
        state_d        = S_FETCH;
        decode_illegal = 1'b1;
      end
    endcase

    if (timeout) state_d = S_FETCH;

    // A FETCH timeout re-enters FETCH, so the count must clear explicitly.
    if (timeout || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (waiting && (MEM_TIMEOUT != 0)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_write_o    = 1'b0;
    adr_src_o      = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    reg_write_o    = 1'b0;
    alu_src_a_o    = SRC_A_PC;
    alu_src_b_o    = SRC_B_RS2;
    result_src_o   = RES_ALUOUT;
    ALU_CO_o       = ALU_CO_ADD;
    is_immediate_o = 1'b0;
    illegal_o      = decode_illegal | timeout;
    state_o        = state_q;

    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = SRC_B_FOUR;
        result_src_o = RES_ALURESULT;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = RES_MEMDATA;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = SRC_A_RS1;
        ALU_CO_o    = ALU_CO_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_o    = SRC_A_RS1;
        alu_src_b_o    = SRC_B_IMM;
        ALU_CO_o       = ALU_CO_FUNCT;
        is_immediate_o = 1'b1;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_JAL: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_FOUR;
        pc_write_o  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o = SRC_A_RS1;
        ALU_CO_o    = ALU_CO_SUB;
        pc_write_o  = zero_i;
      end
      S_LUI: begin
        alu_src_a_o = SRC_A_ZERO;
        alu_src_b_o = SRC_B_IMM;
      end
      default: ;
    endcase
  end

endmodule
